// File: rtl/pipeline_perf_monitor.sv
// Commit, CPI and branch-statistics counters with a start/stop/clear FSM; PERF_SATURATE_EN makes counters saturate instead of wrap.
// Latency: counters update on the sampling edge; rd_data is registered one edge after rd_sel (pre-increment view).
// Backpressure: none, every input is a single-cycle strobe that is always accepted.
module pipeline_perf_monitor #(
    parameter int CNT_W  = 32,
    parameter int NUM_EV = 4,
    parameter int SEL_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              commit_valid,
    input  logic              br_valid,
    input  logic              br_pred_taken,
    input  logic              br_actual_taken,
    input  logic [NUM_EV-1:0] ev_in,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic [1:0]        state,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RUN_WAIT   = 2'd1,
        RUN_ACTIVE = 2'd2,
        FROZEN     = 2'd3
    } state_t;

    // Counter slots; first/last_commit are captured indices and live outside this array.
    localparam int C_CYC = 0;
    localparam int C_COM = 1;
    localparam int C_BRT = 2;
    localparam int C_BRK = 3;
    localparam int C_BRC = 4;
    localparam int C_EV  = 5;
    localparam int NCNT  = C_EV + NUM_EV;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                        state_q;
    state_t                        state_d;
    logic                          count_en;
    logic [NCNT-1:0][CNT_W-1:0]    cnt_q;
    logic [NCNT-1:0][CNT_W-1:0]    cnt_d;
    logic [NCNT-1:0]               cnt_inc;
    logic                          wrap_hit;
    logic [CNT_W-1:0]              first_commit;
    logic [CNT_W-1:0]              last_commit;
    logic [CNT_W-1:0]              commit_idx;
    logic [CNT_W-1:0]              active_span;
    logic [CNT_W-1:0]              rd_next;
    logic [31:0]                   sel_ext;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef PERF_SATURATE_EN
        return (&v) ? v : v + ONE;
`else
        return v + ONE;
`endif
    endfunction

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // stop outranks start, so a simultaneous start is never honoured.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:       if (start && !stop) state_d = RUN_WAIT;
                RUN_WAIT:   if (stop) state_d = FROZEN;
                            else if (commit_valid) state_d = RUN_ACTIVE;
                RUN_ACTIVE: if (stop) state_d = FROZEN;
                FROZEN:     if (start && !stop)
                                state_d = (cnt_q[C_COM] != '0) ? RUN_ACTIVE : RUN_WAIT;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        count_en = (state_q == RUN_WAIT) || (state_q == RUN_ACTIVE);
    end

    always_comb begin
        cnt_inc        = '0;
        cnt_inc[C_CYC] = count_en;
        cnt_inc[C_COM] = count_en && commit_valid;
        cnt_inc[C_BRT] = count_en && br_valid;
        cnt_inc[C_BRK] = count_en && br_valid && br_actual_taken;
        cnt_inc[C_BRC] = count_en && br_valid && (br_pred_taken == br_actual_taken);
        for (int i = 0; i < NUM_EV; i++) begin
            cnt_inc[C_EV+i] = count_en && ev_in[i];
        end
        // An increment attempted at all-ones flags overflow in both wrap and saturate builds.
        wrap_hit = 1'b0;
        cnt_d    = cnt_q;
        for (int k = 0; k < NCNT; k++) begin
            if (cnt_inc[k]) begin
                cnt_d[k] = bump(cnt_q[k]);
                if (&cnt_q[k]) begin
                    wrap_hit = 1'b1;
                end
            end
        end
        commit_idx = bump(cnt_q[C_CYC]);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q        <= '0;
            first_commit <= '0;
            last_commit  <= '0;
            overflow     <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (wrap_hit) begin
                overflow <= 1'b1;
            end
            if (count_en && commit_valid) begin
                last_commit <= commit_idx;
                if (cnt_q[C_COM] == '0) begin
                    first_commit <= commit_idx;
                end
            end
        end
    end

    always_comb begin
        sel_ext     = 32'(rd_sel);
        active_span = (cnt_q[C_COM] == '0) ? '0 : last_commit - first_commit + ONE;
        rd_next     = '0;
        case (sel_ext)
            32'd0: rd_next = cnt_q[C_CYC];
            32'd1: rd_next = cnt_q[C_COM];
            32'd2: rd_next = first_commit;
            32'd3: rd_next = last_commit;
            32'd4: rd_next = active_span;
            32'd5: rd_next = cnt_q[C_BRT];
            32'd6: rd_next = cnt_q[C_BRK];
            32'd7: rd_next = cnt_q[C_BRC];
            32'd8: rd_next = cnt_q[C_BRT] - cnt_q[C_BRC];
            default: begin
                for (int i = 0; i < NUM_EV; i++) begin
                    if (sel_ext == 32'(9 + i)) begin
                        rd_next = cnt_q[C_EV+i];
                    end
                end
            end
        endcase
    end

    // Reads see the counters as they stand at the edge, not the values being written.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Bench for pipeline_perf_monitor at CNT_W=4: directed scenarios then random traffic against an unbounded-count model.
module tb_pipeline_perf_monitor;
    localparam int     CNT_W  = 4;
    localparam int     NUM_EV = 4;
    localparam int     SEL_W  = 4;
    localparam longint MAXV   = 15;

    logic              clk = 1'b0;
    logic              rst, start, stop, clear, commit_valid;
    logic              br_valid, br_pred_taken, br_actual_taken;
    logic [NUM_EV-1:0] ev_in;
    logic [SEL_W-1:0]  rd_sel;
    logic [CNT_W-1:0]  rd_data;
    logic [1:0]        state;
    logic              overflow;

    int tests = 0;
    int fails = 0;

    // Model keeps true (unbounded) event counts since the last clear; the register view is derived on read.
    int     m_state;
    longint m_cyc, m_com, m_bt, m_btk, m_bc, m_first, m_last;
    longint m_ev [NUM_EV];

    always #5 clk = ~clk;

    pipeline_perf_monitor #(.CNT_W(CNT_W), .NUM_EV(NUM_EV), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .commit_valid(commit_valid), .br_valid(br_valid),
        .br_pred_taken(br_pred_taken), .br_actual_taken(br_actual_taken),
        .ev_in(ev_in), .rd_sel(rd_sel), .rd_data(rd_data),
        .state(state), .overflow(overflow)
    );

    function automatic longint red(longint n);
`ifdef PERF_SATURATE_EN
        return (n > MAXV) ? MAXV : n;
`else
        return n % (MAXV + 1);
`endif
    endfunction

    function automatic bit m_ovf();
        bit o;
        o = (m_cyc > MAXV) || (m_com > MAXV) || (m_bt > MAXV) || (m_btk > MAXV) || (m_bc > MAXV);
        for (int i = 0; i < NUM_EV; i++) o = o || (m_ev[i] > MAXV);
        return o;
    endfunction

    function automatic logic [31:0] m_read(int sel);
        longint v;
        v = 0;
        case (sel)
            0: v = red(m_cyc);
            1: v = red(m_com);
            2: v = red(m_first);
            3: v = red(m_last);
            4: v = (red(m_com) == 0) ? 0 : (red(m_last) - red(m_first) + 1 + (MAXV + 1)) % (MAXV + 1);
            5: v = red(m_bt);
            6: v = red(m_btk);
            7: v = red(m_bc);
            8: v = (red(m_bt) - red(m_bc) + (MAXV + 1)) % (MAXV + 1);
            default: if (sel >= 9 && sel < 9 + NUM_EV) v = red(m_ev[sel-9]);
        endcase
        return 32'(v);
    endfunction

    task automatic m_zero();
        m_state = 0;
        m_cyc = 0; m_com = 0; m_bt = 0; m_btk = 0; m_bc = 0; m_first = 0; m_last = 0;
        for (int i = 0; i < NUM_EV; i++) m_ev[i] = 0;
    endtask

    task automatic m_edge();
        bit counted;
        int nxt;
        if (rst || clear) begin
            m_zero();
            return;
        end
        counted = (m_state == 1) || (m_state == 2);
        nxt     = m_state;
        case (m_state)
            0:       if (start && !stop) nxt = 1;
            1:       if (stop) nxt = 3; else if (commit_valid) nxt = 2;
            2:       if (stop) nxt = 3;
            default: if (start && !stop) nxt = (red(m_com) != 0) ? 2 : 1;
        endcase
        if (counted) begin
            if (commit_valid) begin
                if (red(m_com) == 0) m_first = m_cyc + 1;
                m_last = m_cyc + 1;
                m_com++;
            end
            m_cyc++;
            if (br_valid) begin
                m_bt++;
                if (br_actual_taken) m_btk++;
                if (br_pred_taken == br_actual_taken) m_bc++;
            end
            for (int i = 0; i < NUM_EV; i++) if (ev_in[i]) m_ev[i]++;
        end
        m_state = nxt;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [31:0] exp_rd;
        exp_rd = rst ? 32'd0 : m_read(int'(rd_sel));
        m_edge();
        @(posedge clk);
        #1;
        chk("rd_data", 32'(rd_data), exp_rd);
        chk("state", 32'(state), 32'(m_state));
        chk("overflow", 32'(overflow), 32'(m_ovf()));
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; clear = 0; commit_valid = 0;
        br_valid = 0; br_pred_taken = 0; br_actual_taken = 0; ev_in = '0;
    endtask

    task automatic rd_check(int sel, logic [31:0] exp, string tag);
        rd_sel = SEL_W'(sel);
        step();
        chk(tag, 32'(rd_data), exp);
    endtask

    initial begin
        idle_inputs();
        rd_sel = '0;
        m_zero();
        rst = 1;
        step();
        step();
        rst = 0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_rd", 32'(rd_data), 32'd0);

        // Idle commits without start count nothing.
        commit_valid = 1;
        repeat (20) step();
        chk("t1_state", 32'(state), 32'd0);
        for (int s = 0; s < 16; s++) rd_check(s, 32'd0, "t1_rd");
        commit_valid = 0;

        // Commits at 3,4,7, branch table, stop in counted cycle 10.
        start = 1;
        step();
        start = 0;
        chk("t2_wait", 32'(state), 32'd1);
        for (int c = 1; c <= 10; c++) begin
            commit_valid    = (c == 3 || c == 4 || c == 7);
            stop            = (c == 10);
            br_valid        = (c == 1 || c == 2 || c == 5 || c == 6 || c == 8);
            br_pred_taken   = (c == 1 || c == 5);
            br_actual_taken = (c == 1 || c == 6);
            step();
        end
        idle_inputs();
        chk("t2_frozen", 32'(state), 32'd3);
        commit_valid = 1;
        ev_in = '1;
        repeat (5) step();
        idle_inputs();
        rd_check(0, 32'd10, "t2_cycles");
        rd_check(1, 32'd3, "t2_commits");
        rd_check(2, 32'd3, "t2_first");
        rd_check(3, 32'd7, "t2_last");
        rd_check(4, 32'd5, "t2_active");
        rd_check(5, 32'd5, "t3_br_total");
        rd_check(6, 32'd2, "t3_br_taken");
        rd_check(7, 32'd3, "t3_br_correct");
        rd_check(8, 32'd2, "t3_br_miss");

        // Priority and resume behaviour.
        start = 1;
        step();
        start = 0;
        chk("t4_resume_active", 32'(state), 32'd2);
        start = 1; stop = 1; clear = 1;
        step();
        idle_inputs();
        chk("t4_clear_idle", 32'(state), 32'd0);
        rd_check(0, 32'd0, "t4_clr_cycles");
        rd_check(1, 32'd0, "t4_clr_commits");
        chk("t4_clr_ovf", 32'(overflow), 32'd0);
        start = 1;
        step();
        start = 0;
        chk("t4_wait", 32'(state), 32'd1);
        start = 1; stop = 1;
        step();
        idle_inputs();
        chk("t4_stop_wins", 32'(state), 32'd3);
        start = 1;
        step();
        start = 0;
        chk("t4_resume_wait", 32'(state), 32'd1);

        // 17 counted event cycles on a 4-bit counter.
        clear = 1;
        step();
        clear = 0;
        start = 1;
        step();
        start = 0;
        ev_in = 4'b0001;
        repeat (16) step();
        stop = 1;
        step();
        idle_inputs();
        chk("t5_ovf", 32'(overflow), 32'd1);
`ifdef PERF_SATURATE_EN
        rd_check(9, 32'd15, "t5_ev0");
`else
        rd_check(9, 32'd1, "t5_ev0");
`endif
        clear = 1;
        step();
        clear = 0;
        chk("t5_ovf_clr", 32'(overflow), 32'd0);
        rd_check(9, 32'd0, "t5_ev0_clr");

        // Read latency against a concurrent increment.
        start = 1;
        step();
        start = 0;
        rd_sel = 0;
        commit_valid = 1;
        step();
        step();
        rd_sel = 1;
        step();
        chk("t6_pre_inc", 32'(rd_data), 32'd2);
        commit_valid = 0;
        step();
        chk("t6_post_inc", 32'(rd_data), 32'd3);

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            rst             = ($urandom_range(0, 299) == 0);
            start           = ($urandom_range(0, 9) == 0);
            stop            = !start && ($urandom_range(0, 14) == 0);
            clear           = ($urandom_range(0, 49) == 0);
            commit_valid    = ($urandom_range(0, 1) == 1);
            br_valid        = ($urandom_range(0, 2) == 0);
            br_pred_taken   = ($urandom_range(0, 1) == 1);
            br_actual_taken = ($urandom_range(0, 1) == 1);
            ev_in           = NUM_EV'($urandom);
            rd_sel          = SEL_W'($urandom);
            step();
        end
        rst = 0;
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
